// File: rtl/result_change_logger.sv
// Change-triggered capture of the upstream result bus into a timestamped FWFT FIFO.
// Each entry is {value, timestamp}; a full FIFO drops new changes and flags overflow.
module result_change_logger #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned TS_W   = 8,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      clear,
    input  logic [DATA_W-1:0]         y_in,
    input  logic                      rd_en,
    output logic [DATA_W+TS_W-1:0]    rd_data,
    output logic                      rd_valid,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = DATA_W + TS_W;

    logic [TS_W-1:0]   ts_q;
    logic [DATA_W-1:0] prev_q;
    logic              primed_q;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q, count_d;
    logic              overflow_q;
    logic [EW-1:0]     mem_q [DEPTH];

    logic sample, change, pop, push, drop, empty, is_full;

    always_comb begin
        empty   = (count_q == '0);
        is_full = (count_q == (AW+1)'(DEPTH));
        sample  = enable && !clear;
        change  = sample && (!primed_q || (y_in != prev_q));
        pop     = rd_en && !empty && !clear;
        // A simultaneous pop frees the slot, so a full FIFO can still accept the push.
        push    = change && (!is_full || pop);
        drop    = change && is_full && !pop;
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q       <= '0;
            prev_q     <= '0;
            primed_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (clear) begin
            ts_q       <= '0;
            primed_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (enable) begin
                ts_q <= ts_q + TS_W'(1);
            end
            // prev tracks the bus even when the entry is dropped, so no late duplicate.
            if (change) begin
                prev_q   <= y_in;
                primed_q <= 1'b1;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= {y_in, ts_q};
        end
    end

    always_comb begin
        rd_valid = !empty;
        rd_data  = empty ? '0 : mem_q[rd_ptr_q];
        full     = is_full;
        count    = count_q;
        overflow = overflow_q;
    end

endmodule

// File: tb/tb_result_change_logger.sv
// Directed bench for result_change_logger; expected entries are hand-computed {value, ts}.
module tb_result_change_logger;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        clear;
    logic [3:0]  y_in;
    logic        rd_en;
    logic [11:0] rd_data;
    logic        rd_valid;
    logic        full;
    logic [3:0]  count;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    result_change_logger #(
        .DATA_W (4),
        .TS_W   (8),
        .DEPTH  (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .clear    (clear),
        .y_in     (y_in),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check(input string tag, input logic [3:0] v, input logic [7:0] t);
        check({tag, " valid"}, 32'(rd_valid), 32'd1);
        check({tag, " data"}, 32'(rd_data), 32'({v, t}));
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        clear  = 1'b0;
        y_in   = 4'h0;
        rd_en  = 1'b0;
        tick();
        tick();
        check("reset rd_data", 32'(rd_data), 32'd0);
        check("reset rd_valid", 32'(rd_valid), 32'd0);
        check("reset full", 32'(full), 32'd0);
        check("reset count", 32'(count), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        tick();

        // Constant input: only the first sample is logged, at ts 0.
        enable = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("hold count", 32'(count), 32'd1);
        check("hold valid", 32'(rd_valid), 32'd1);
        check("hold head", 32'(rd_data), 32'h000);

        // Change sequence with ts 0..11.
        do_clear();
        for (int k = 0; k < 12; k++) begin
            y_in = (k < 2) ? 4'h0 : (k < 6) ? 4'hA : 4'h6;
            tick();
        end
        check("seq count", 32'(count), 32'd3);
        pop_check("seq e0", 4'h0, 8'd0);
        pop_check("seq e1", 4'hA, 8'd2);
        pop_check("seq e2", 4'h6, 8'd6);
        check("seq drained", 32'(rd_valid), 32'd0);

        // Toggle every edge: ts k pushes value (k odd ? F : 0).
        do_clear();
        for (int k = 0; k < 8; k++) begin
            y_in = k[0] ? 4'hF : 4'h0;
            tick();
        end
        check("fill full", 32'(full), 32'd1);
        check("fill count", 32'(count), 32'd8);
        check("fill ovf", 32'(overflow), 32'd0);
        // Full with simultaneous pop at ts 8: head {0,0} leaves, {0,8} joins.
        y_in  = 4'h0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("fullpop count", 32'(count), 32'd8);
        check("fullpop ovf", 32'(overflow), 32'd0);
        y_in = 4'hF;
        tick();
        check("drop ovf", 32'(overflow), 32'd1);
        check("drop count", 32'(count), 32'd8);
        y_in = 4'h0;
        tick();
        enable = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            pop_check($sformatf("drain e%0d", k), k[0] ? 4'hF : 4'h0, 8'(k));
        end
        check("drain valid", 32'(rd_valid), 32'd0);
        check("drain ovf sticky", 32'(overflow), 32'd1);

        // ts held at 11 across a long disable.
        y_in = 4'h5;
        for (int i = 0; i < 300; i++) tick();
        check("disabled count", 32'(count), 32'd0);
        enable = 1'b1;
        tick();
        pop_check("resume", 4'h5, 8'd11);
        // ts now 13; run to the 255 -> 0 wrap.
        for (int t = 13; t < 255; t++) tick();
        y_in = 4'h3;
        tick();
        y_in = 4'h4;
        tick();
        check("wrap count", 32'(count), 32'd2);
        pop_check("wrap e0", 4'h3, 8'd255);
        pop_check("wrap e1", 4'h4, 8'd0);

        // Clear with count=5 and overflow=1.
        do_clear();
        for (int k = 0; k < 10; k++) begin
            y_in = k[0] ? 4'hF : 4'h0;
            tick();
        end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        check("pre-clear count", 32'(count), 32'd5);
        check("pre-clear ovf", 32'(overflow), 32'd1);
        enable = 1'b1;
        y_in   = 4'h7;
        rd_en  = 1'b1;
        clear  = 1'b1;
        tick();
        clear = 1'b0;
        rd_en = 1'b0;
        check("clear count", 32'(count), 32'd0);
        check("clear ovf", 32'(overflow), 32'd0);
        check("clear valid", 32'(rd_valid), 32'd0);
        tick();
        check("post-clear count", 32'(count), 32'd1);
        check("post-clear head", 32'(rd_data), 32'h700);

        // Async reset mid-stream, then push into empty FIFO with rd_en high.
        y_in = 4'h2;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst count", 32'(count), 32'd0);
        check("async rst valid", 32'(rd_valid), 32'd0);
        check("async rst data", 32'(rd_data), 32'd0);
        tick();
        check("rst held count", 32'(count), 32'd0);
        rst_n = 1'b1;
        y_in  = 4'h9;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("empty push+rd count", 32'(count), 32'd1);
        check("empty push+rd head", 32'(rd_data), 32'h900);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
